// File: rtl/register8_bank_master.sv
// register8_bank_master: command-driven initiator for an 8x8 register bank.
// Accepts write / dual-read commands on a valid/ready stream and drives the
// bank's write port and two combinational read ports. Read data is returned
// on a valid/ready response stream. Writes to X0 are dropped and counted.
//
// Optional build macro REG8_MASTER_WRITE_VERIFY_EN adds a VERIFY state after
// WRITE that reads the written register back, flags mismatches on a sticky
// verify_err output and returns the readback as a response tagged rsp_is_wr.
`timescale 1ns/1ps

module register8_bank_master #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_waddr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [ADDR_W-1:0] cmd_raddr1,
  input  logic [ADDR_W-1:0] cmd_raddr2,
  // response stream
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data1,
  output logic [DATA_W-1:0] rsp_data2,
`ifdef REG8_MASTER_WRITE_VERIFY_EN
  output logic              rsp_is_wr,
  output logic              verify_err,
`endif
  // register bank ports
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic [ADDR_W-1:0] rf_ra1,
  output logic [ADDR_W-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  // statistics
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  drop_count
);

  localparam int unsigned ST_W = 3;

  localparam logic [ST_W-1:0] IDLE   = 3'd0;
  localparam logic [ST_W-1:0] WRITE  = 3'd1;
  localparam logic [ST_W-1:0] READ   = 3'd2;
  localparam logic [ST_W-1:0] RESP   = 3'd3;
`ifdef REG8_MASTER_WRITE_VERIFY_EN
  localparam logic [ST_W-1:0] VERIFY = 3'd4;
`endif

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] state_nxt;

  logic cmd_accept;
  logic wr_accept;
  logic drop_accept;
  logic rd_accept;

  // Command decode: cmd_ready is the registered "in IDLE" flag.
  always_comb begin
    cmd_accept  = cmd_valid & cmd_ready;
    wr_accept   = 1'b0;
    drop_accept = 1'b0;
    rd_accept   = 1'b0;
    if (cmd_accept && (state == IDLE)) begin
      if (cmd_op) begin
        rd_accept = 1'b1;
      end else if (cmd_waddr != '0) begin
        wr_accept = 1'b1;
      end else begin
        drop_accept = 1'b1;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_accept) begin
          state_nxt = READ;
        end else if (wr_accept) begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
`ifdef REG8_MASTER_WRITE_VERIFY_EN
        state_nxt = VERIFY;
`else
        state_nxt = IDLE;
`endif
      end
`ifdef REG8_MASTER_WRITE_VERIFY_EN
      VERIFY: state_nxt = RESP;
`endif
      READ: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake and write-enable outputs, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rf_we     <= 1'b0;
    end else begin
      cmd_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      rf_we     <= (state_nxt == WRITE);
    end
  end

  // Bank address/data: latched on accept, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wa  <= '0;
      rf_wd  <= '0;
      rf_ra1 <= '0;
      rf_ra2 <= '0;
    end else begin
      if (wr_accept) begin
        rf_wa <= cmd_waddr;
        rf_wd <= cmd_wdata;
      end
      if (rd_accept) begin
        rf_ra1 <= cmd_raddr1;
        rf_ra2 <= cmd_raddr2;
      end
`ifdef REG8_MASTER_WRITE_VERIFY_EN
      // Point read port 1 at the just-written register for readback.
      if (state == WRITE) begin
        rf_ra1 <= rf_wa;
      end
`endif
    end
  end

  // Response data capture from the bank's combinational read ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data1 <= '0;
      rsp_data2 <= '0;
    end else begin
      if (state == READ) begin
        rsp_data1 <= rf_rd1;
        rsp_data2 <= rf_rd2;
      end
`ifdef REG8_MASTER_WRITE_VERIFY_EN
      if (state == VERIFY) begin
        rsp_data1 <= rf_rd1;
      end
`endif
    end
  end

`ifdef REG8_MASTER_WRITE_VERIFY_EN
  // Response tag and sticky readback-mismatch flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_is_wr  <= 1'b0;
      verify_err <= 1'b0;
    end else begin
      if (state == READ) begin
        rsp_is_wr <= 1'b0;
      end
      if (state == VERIFY) begin
        rsp_is_wr <= 1'b1;
        if (rf_rd1 != rf_wd) begin
          verify_err <= 1'b1;
        end
      end
    end
  end
`endif

  // Saturating statistics: a write counts on the edge that commits it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_count   <= '0;
      drop_count <= '0;
    end else begin
      if ((state == WRITE) && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_W'(1);
      end
      if (drop_accept && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_register8_bank_master.sv
// Directed bench for register8_bank_master with a behavioural 8x8 bank model.
`timescale 1ns/1ps

module tb_register8_bank_master;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [2:0] cmd_waddr;
  logic [7:0] cmd_wdata;
  logic [2:0] cmd_raddr1;
  logic [2:0] cmd_raddr2;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data1;
  logic [7:0] rsp_data2;
  logic       rf_we;
  logic [2:0] rf_wa;
  logic [7:0] rf_wd;
  logic [2:0] rf_ra1;
  logic [2:0] rf_ra2;
  logic [7:0] rf_rd1;
  logic [7:0] rf_rd2;
  logic [15:0] wr_count;
  logic [15:0] drop_count;
`ifdef REG8_MASTER_WRITE_VERIFY_EN
  logic       rsp_is_wr;
  logic       verify_err;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int we_cycles = 0;
  logic [7:0] bank [8];
  logic [7:0] corrupt = 8'h00;

  register8_bank_master dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_waddr  (cmd_waddr),
    .cmd_wdata  (cmd_wdata),
    .cmd_raddr1 (cmd_raddr1),
    .cmd_raddr2 (cmd_raddr2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data1  (rsp_data1),
    .rsp_data2  (rsp_data2),
`ifdef REG8_MASTER_WRITE_VERIFY_EN
    .rsp_is_wr  (rsp_is_wr),
    .verify_err (verify_err),
`endif
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .wr_count   (wr_count),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: X0 reads zero; corrupt injects a read-port-1 error.
  initial begin
    for (int i = 0; i < 8; i++) bank[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (rf_we && (rf_wa != 3'd0)) bank[rf_wa] <= rf_wd;
    if (rf_we) we_cycles <= we_cycles + 1;
  end
  assign rf_rd1 = ((rf_ra1 == 3'd0) ? 8'h00 : bank[rf_ra1]) ^ corrupt;
  assign rf_rd2 = (rf_ra2 == 3'd0) ? 8'h00 : bank[rf_ra2];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 20) begin
      step();
      n++;
    end
    if (n == 20) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    int base;
    wait_ready();
    base = we_cycles;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_waddr = a; cmd_wdata = d;
    step();
    cmd_valid = 1'b0;
    chk("wr_we_on", 32'(rf_we), 32'd1);
    chk("wr_wa", 32'(rf_wa), 32'(a));
    chk("wr_wd", 32'(rf_wd), 32'(d));
    chk("wr_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    step();
    chk("wr_we_off", 32'(rf_we), 32'd0);
    chk("wr_we_one_cycle", 32'(we_cycles - base), 32'd1);
`ifdef REG8_MASTER_WRITE_VERIFY_EN
    step();
    chk("vfy_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("vfy_rsp_is_wr", 32'(rsp_is_wr), 32'd1);
    chk("vfy_rsp_data1", 32'(rsp_data1), 32'(d ^ corrupt));
    step();
    chk("vfy_rsp_done", 32'(rsp_valid), 32'd0);
`endif
  endtask

  task automatic do_read(input logic [2:0] r1, input logic [2:0] r2,
                         input logic [7:0] e1, input logic [7:0] e2);
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_raddr1 = r1; cmd_raddr2 = r2;
    step();
    cmd_valid = 1'b0;
    chk("rd_valid_early", 32'(rsp_valid), 32'd0);
    chk("rd_ra1", 32'(rf_ra1), 32'(r1));
    chk("rd_ra2", 32'(rf_ra2), 32'(r2));
    step();
    chk("rd_valid", 32'(rsp_valid), 32'd1);
    chk("rd_data1", 32'(rsp_data1), 32'(e1));
    chk("rd_data2", 32'(rsp_data2), 32'(e2));
    chk("rd_cmd_ready_busy", 32'(cmd_ready), 32'd0);
`ifdef REG8_MASTER_WRITE_VERIFY_EN
    chk("rd_is_wr", 32'(rsp_is_wr), 32'd0);
`endif
    if (rsp_ready) begin
      step();
      chk("rd_valid_done", 32'(rsp_valid), 32'd0);
      chk("rd_idle_again", 32'(cmd_ready), 32'd1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_waddr = 3'd0; cmd_wdata = 8'h00;
    cmd_raddr1 = 3'd0; cmd_raddr2 = 3'd0; rsp_ready = 1'b1;

    // 1: reset values, then read of unwritten registers
    step(); step();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rf_we", 32'(rf_we), 32'd0);
    chk("rst_rf_wa", 32'(rf_wa), 32'd0);
    chk("rst_rf_wd", 32'(rf_wd), 32'd0);
    chk("rst_rf_ra1", 32'(rf_ra1), 32'd0);
    chk("rst_rf_ra2", 32'(rf_ra2), 32'd0);
    chk("rst_rsp_data1", 32'(rsp_data1), 32'd0);
    chk("rst_rsp_data2", 32'(rsp_data2), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    rst = 1'b0;
    do_read(3'd1, 3'd2, 8'h00, 8'h00);

    // 2: writes then read-back
    do_write(3'd1, 8'hAA);
    do_write(3'd2, 8'hBB);
    do_read(3'd1, 3'd2, 8'hAA, 8'hBB);
    chk("t2_wr_count", 32'(wr_count), 32'd2);

    // 3: write to X0 is dropped
    begin
      int base;
      wait_ready();
      base = we_cycles;
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_waddr = 3'd0; cmd_wdata = 8'hFF;
      step();
      cmd_valid = 1'b0;
      chk("t3_still_idle", 32'(cmd_ready), 32'd1);
      chk("t3_we_low", 32'(rf_we), 32'd0);
      chk("t3_drop_count", 32'(drop_count), 32'd1);
      step();
      chk("t3_no_we_cycles", 32'(we_cycles - base), 32'd0);
      chk("t3_wr_count", 32'(wr_count), 32'd2);
    end
    do_read(3'd0, 3'd1, 8'h00, 8'hAA);

    // 4: response back-pressure holds data
    do_write(3'd3, 8'h33);
    do_write(3'd4, 8'h44);
    rsp_ready = 1'b0;
    do_read(3'd3, 3'd4, 8'h33, 8'h44);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_valid", 32'(rsp_valid), 32'd1);
      chk("t4_hold_data1", 32'(rsp_data1), 32'h33);
      chk("t4_hold_data2", 32'(rsp_data2), 32'h44);
      chk("t4_hold_busy", 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    chk("t4_released", 32'(rsp_valid), 32'd0);
    chk("t4_idle", 32'(cmd_ready), 32'd1);
    chk("t4_wr_count", 32'(wr_count), 32'd4);

    // 5: reset in the middle of a read aborts it
    wait_ready();
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_raddr1 = 3'd3; cmd_raddr2 = 3'd4;
    step();
    cmd_valid = 1'b0;
    chk("t5_in_read", 32'(cmd_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_idle", 32'(cmd_ready), 32'd1);
    chk("t5_wr_count", 32'(wr_count), 32'd0);
    chk("t5_drop_count", 32'(drop_count), 32'd0);
    step();
    chk("t5_no_late_rsp", 32'(rsp_valid), 32'd0);
    do_write(3'd7, 8'h77);
    do_read(3'd7, 3'd0, 8'h77, 8'h00);
    chk("t5_wr_count_after", 32'(wr_count), 32'd1);

`ifdef REG8_MASTER_WRITE_VERIFY_EN
    // 6: write verify and sticky error
    do_write(3'd5, 8'hEE);
    chk("t6_no_err", 32'(verify_err), 32'd0);
    corrupt = 8'h01;
    do_write(3'd6, 8'h12);
    corrupt = 8'h00;
    chk("t6_err_set", 32'(verify_err), 32'd1);
    do_read(3'd5, 3'd6, 8'hEE, 8'h12);
    chk("t6_err_sticky", 32'(verify_err), 32'd1);
    do_reset();
    chk("t6_err_cleared", 32'(verify_err), 32'd0);
`endif

    // 7: drop counter saturates at all-ones
    do_reset();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_waddr = 3'd0; cmd_wdata = 8'h5A;
    repeat (65534) @(posedge clk);
    #1;
    chk("t7_drop_fffe", 32'(drop_count), 32'h0000_FFFE);
    step();
    chk("t7_drop_ffff", 32'(drop_count), 32'h0000_FFFF);
    step(); step();
    chk("t7_drop_sat", 32'(drop_count), 32'h0000_FFFF);
    chk("t7_wr_count", 32'(wr_count), 32'd0);
    cmd_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
